// File: rtl/pipelined_prefix_addsub_pkg.sv
// Shared op encodings and elaboration-time helpers for the pipelined prefix adder/subtractor.
// Pipeline depth is derived here so the top and any wrapper agree on latency.
package pipelined_prefix_addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_log2w(input int width);
    return clog2(width);
  endfunction

  // Register stages after the operand stage; the last one absorbs any leftover levels.
  function automatic int calc_n_pipe(input int width, input int reg_levels);
    int levels;
    levels = clog2(width);
    return (levels + reg_levels - 1) / reg_levels;
  endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone black cell: combines a (g,p) span with the adjacent lower span.
// Purely combinational.
module prefix_gp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/pipelined_prefix_addsub.sv
// Pipelined Kogge-Stone add/sub (ADD/ADC/SUB/SBB) with cout/ovf/zero flags and a sideband tag.
// N_PIPE+1 register stages; valid/ready with full backpressure, bubbles collapse behind a stall.
module pipelined_prefix_addsub
  import pipelined_prefix_addsub_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int REG_LEVELS = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LOG2W  = calc_log2w(WIDTH);
  localparam int N_PIPE = calc_n_pipe(WIDTH, REG_LEVELS);

  // Stages 0..N_PIPE-1 hold prefix state; vld[N_PIPE] is the output register.
  logic [WIDTH-1:0] st_g   [N_PIPE];
  logic [WIDTH-1:0] st_p   [N_PIPE];
  logic [WIDTH-1:0] st_x   [N_PIPE];
  logic             st_c   [N_PIPE];
  logic             st_sub [N_PIPE];
  logic [TAG_W-1:0] st_tag [N_PIPE];
  logic [N_PIPE:0]  vld;
  logic [N_PIPE:0]  adv;

  logic [WIDTH-1:0] nx_g [N_PIPE];
  logic [WIDTH-1:0] nx_p [N_PIPE];

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  always_comb begin
    b_eff = b;
    c_eff = 1'b0;
    case (op)
      OP_ADD: c_eff = 1'b0;
      OP_ADC: c_eff = cin;
      OP_SUB: begin
        b_eff = ~b;
        c_eff = 1'b1;
      end
      OP_SBB: begin
        b_eff = ~b;
        c_eff = ~cin;
      end
      default: c_eff = 1'b0;
    endcase
  end

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin
    adv = '0;
    adv[N_PIPE] = !vld[N_PIPE] || out_ready;
    for (int k = N_PIPE - 1; k >= 0; k--) begin
      adv[k] = !vld[k] || adv[k+1];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[N_PIPE];

  // Prefix network between stage k and k+1; levels at or beyond LOG2W pass through.
  for (genvar k = 0; k < N_PIPE; k++) begin : g_stage
    for (genvar j = 0; j < REG_LEVELS; j++) begin : g_lvl
      localparam int LV   = k * REG_LEVELS + j;
      localparam int DIST = 1 << LV;
      logic [WIDTH-1:0] gi;
      logic [WIDTH-1:0] pi;
      logic [WIDTH-1:0] go;
      logic [WIDTH-1:0] po;

      if (j == 0) begin : g_src_reg
        assign gi = st_g[k];
        assign pi = st_p[k];
      end else begin : g_src_lvl
        assign gi = g_lvl[j-1].go;
        assign pi = g_lvl[j-1].po;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (LV < LOG2W && i >= DIST) begin : g_cell
          prefix_gp_cell u_cell (
            .g_hi(gi[i]),
            .p_hi(pi[i]),
            .g_lo(gi[i-DIST]),
            .p_lo(pi[i-DIST]),
            .g   (go[i]),
            .p   (po[i])
          );
        end else begin : g_pass
          assign go[i] = gi[i];
          assign po[i] = pi[i];
        end
      end
    end

    assign nx_g[k] = g_lvl[REG_LEVELS-1].go;
    assign nx_p[k] = g_lvl[REG_LEVELS-1].po;
  end

  // Group (g,p) over [i:0] plus the carry-in give the carry into each bit.
  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] fin_p;
  logic             fin_c;
  logic [WIDTH-1:0] carries;
  logic             carry_raw;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  assign fin_g     = nx_g[N_PIPE-1];
  assign fin_p     = nx_p[N_PIPE-1];
  assign fin_c     = st_c[N_PIPE-1];
  assign carries   = {fin_g[WIDTH-2:0] | (fin_p[WIDTH-2:0] & {(WIDTH-1){fin_c}}), fin_c};
  assign carry_raw = fin_g[WIDTH-1] | (fin_p[WIDTH-1] & fin_c);
  assign res_sum   = st_x[N_PIPE-1] ^ carries;
  assign res_cout  = carry_raw ^ st_sub[N_PIPE-1];
  assign res_ovf   = carries[WIDTH-1] ^ carry_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      tag_out <= '0;
      for (int k = 0; k < N_PIPE; k++) begin
        st_g[k]   <= '0;
        st_p[k]   <= '0;
        st_x[k]   <= '0;
        st_c[k]   <= 1'b0;
        st_sub[k] <= 1'b0;
        st_tag[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          st_g[0]   <= a & b_eff;
          st_p[0]   <= a ^ b_eff;
          st_x[0]   <= a ^ b_eff;
          st_c[0]   <= c_eff;
          st_sub[0] <= op[1];
          st_tag[0] <= tag;
        end
      end
      for (int k = 1; k < N_PIPE; k++) begin
        if (adv[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            st_g[k]   <= nx_g[k-1];
            st_p[k]   <= nx_p[k-1];
            st_x[k]   <= st_x[k-1];
            st_c[k]   <= st_c[k-1];
            st_sub[k] <= st_sub[k-1];
            st_tag[k] <= st_tag[k-1];
          end
        end
      end
      // Output fields change only when a new valid result lands, so a stall holds them.
      if (adv[N_PIPE]) begin
        vld[N_PIPE] <= vld[N_PIPE-1];
        if (vld[N_PIPE-1]) begin
          sum     <= res_sum;
          cout    <= res_cout;
          ovf     <= res_ovf;
          zero    <= ~|res_sum;
          tag_out <= st_tag[N_PIPE-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
// Scoreboard bench for pipelined_prefix_addsub at WIDTH=24, REG_LEVELS=2.
module tb_pipelined_prefix_addsub;

  localparam int W   = 24;
  localparam int TW  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [TW-1:0] tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic [TW-1:0] tag_out;

  pipelined_prefix_addsub #(.WIDTH(W), .REG_LEVELS(2), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op       (op),
    .tag      (tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .tag_out  (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  s;
    logic          co;
    logic          ov;
    logic          z;
    logic [TW-1:0] t;
  } res_t;

  res_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic        hold_chk = 1'b0;
  logic [31:0] held;
  res_t        exp_r;
  logic        rnd_done;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic [1:0] o, input logic [TW-1:0] t);
    logic [W:0] full;
    logic       cc;
    res_t       r;
    cc = o[0] ? c : 1'b0;
    if (!o[1]) full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cc};
    else       full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cc};
    r.s  = full[W-1:0];
    r.co = full[W];
    if (!o[1]) r.ov = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    else       r.ov = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    r.z  = (r.s == '0);
    r.t  = t;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic [1:0] o, input logic [TW-1:0] t);
    res_t e;
    int   n;
    e = model(x, y, c, o, t);
    a = x; b = y; cin = c; op = o; tag = t;
    in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Retire results into the scoreboard and verify held outputs during stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_chk) chk("stall_hold", 64'({out_valid, sum, cout, ovf, zero, tag_out}), 64'(held));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 64'(1), 64'(0));
        end else begin
          exp_r = sb_q.pop_front();
          chk("result", 64'({sum, cout, ovf, zero, tag_out}), 64'(exp_r));
          n_out++;
        end
      end
      hold_chk = out_valid && !out_ready;
      held     = {1'b1, sum, cout, ovf, zero, tag_out};
    end else begin
      hold_chk = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int k;
    int base;

    #12;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_outputs", 64'({sum, cout, ovf, zero, tag_out}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // Carry across every bit; also measures accept-to-valid latency.
    send(24'hFFFFFF, 24'h000001, 1'b0, 2'b00, 4'd1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", 64'(k + 1), 64'(LAT));
    idle(3);

    send(24'h000005, 24'h000007, 1'b0, 2'b10, 4'd2);
    send(24'h800000, 24'h000001, 1'b0, 2'b10, 4'd3);
    send(24'h7FFFFF, 24'h000000, 1'b1, 2'b01, 4'd4);
    send(24'h000010, 24'h000010, 1'b1, 2'b11, 4'd5);
    send(24'h000010, 24'h000010, 1'b1, 2'b00, 4'd6);
    send(24'h000010, 24'h000010, 1'b1, 2'b10, 4'd7);
    idle(8);

    // Back-to-back stream of 8 with a stall window.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 2'($urandom), 4'(i));
      end
      begin
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        idle(8);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("drain_rate", 64'(out_valid), 64'(1));
        end
        idle(1);
      end
    join
    idle(15);
    chk("stream_count", 64'(n_out - base), 64'(8));

    // Asynchronous reset with three ops in flight.
    out_ready = 1'b1;
    send(24'h123456, 24'h654321, 1'b0, 2'b00, 4'd9);
    send(24'h0000FF, 24'h000001, 1'b0, 2'b10, 4'd10);
    send(24'hABCDEF, 24'h111111, 1'b1, 2'b01, 4'd11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_outputs", 64'({sum, cout, ovf, zero, tag_out}), 64'(0));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    base = n_out;
    idle(10);
    chk("arst_no_stale", 64'(n_out - base), 64'(0));

    // Random traffic with random backpressure and input gaps.
    base = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(pick(), pick(), 1'($urandom), 2'($urandom), 4'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    idle(20);
    chk("random_count", 64'(n_out - base), 64'(300));
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
